fft_out_reorder: RTL
====================

Name: fft_out_reorder

Overview:
- Downstream stage of the in-place radix-2 FFT core.
- Consumes the core's dual-lane output: two complex results per cycle, delivered while the core's output phase is active.
- Buffers each full frame in a ping-pong register memory.
- Emits the frame as a single-lane, natural-order complex stream with a valid/ready handshake, an index and a last flag, so later blocks need not know the core's pair ordering.

Parameters:
- BW, 16, bit width of each real and imaginary component (matches the FFT core).
- LOG2N, 5, log2 of frame length; N = 2^LOG2N points, N/2 input pairs per frame.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both banks and all counters.
- in_valid  input  1  pair present; driven from the core's output-phase indication.
- in_re0, in_im0  input  BW each  lane-0 sample (upper butterfly output).
- in_re1, in_im1  input  BW each  lane-1 sample (lower butterfly output).
- in_ready  output  1  write bank can accept a pair.
- out_valid  output  1  out_re/out_im/out_index valid.
- out_ready  input  1  downstream accepts the current sample.
- out_re, out_im  output  BW each  natural-order sample.
- out_index  output  LOG2N  frequency bin of the current sample.
- out_last  output  1  high with bin N-1.
- overflow  output  1  sticky: a pair was presented while in_ready=0.

Behaviour:
- Reset (nrst=0, async): both banks empty, wb=0, rb=0, wr_cnt=0, rd_cnt=0, overflow=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_index=0, out_re=0, out_im=0.
  - Reset mid-frame discards all buffered data.
- Pair ordering: accepted pair k (k = 0..N/2-1 within a frame) carries X[k] on lane 0 and X[k+N/2] on lane 1.
- Storage: 2 banks x N words x 2*BW bits ({re,im}).
- Write side: accept = in_valid & in_ready.
  - mem[wb][wr_cnt] <= lane0; mem[wb][wr_cnt+N/2] <= lane1; wr_cnt++.
  - On accepting pair N/2-1: full[wb] <= 1, wb toggles, wr_cnt <= 0.
  - Pairs need not be consecutive; gaps in in_valid hold wr_cnt.
- in_ready = !full[wb], combinational from registered state.
- Overflow: in_valid & !in_ready sets overflow (sticky until reset or flush). The pair is dropped; wr_cnt and memory are unchanged.
- Read side: out_valid = full[rb].
  - out_re/out_im = mem[rb][rd_cnt]; out_index = rd_cnt; out_last = out_valid & (rd_cnt == N-1).
  - When out_valid=0, out_re/out_im/out_index are 0.
  - Handshake out_valid & out_ready: rd_cnt++.
  - On handshake with out_last: full[rb] <= 0, rb toggles, rd_cnt <= 0.
- Output data is held stable while out_valid=1 and out_ready=0.
- Latency: the last pair of a frame is accepted at edge t; out_valid=1 from the cycle after t, showing bin 0. Best case is one output per cycle, N cycles per frame.
- Per-bank state: EMPTY -> FILLING (first pair accepted) -> FULL (pair N/2-1 accepted) -> DRAINING (first output handshake) -> EMPTY (handshake with out_last).
- Simultaneous events:
  - Writing bank wb while draining bank rb in the same cycle is legal (different banks).
  - If both banks are full, in_ready=0. It rises the cycle after the out_last handshake frees the bank wb points to; an in_valid in the freeing cycle itself is an overflow.
- flush (sync, priority over all other activity): same state as reset except the clock-domain timing; overflow cleared.
- Arithmetic: counters wrap only at the rules above. No data arithmetic; samples pass bit-exact.

Test Plan:
- Single frame, N=32: pairs k=0..15 with lane0 re=k, im=-k and lane1 re=k+16, im=-(k+16), in_valid continuous, out_ready=1.
  - Out_valid rises the cycle after pair 15.
  - Outputs re=0..31, im=0..-31, out_index=0..31; out_last only on index 31; in_ready never drops.
- Backpressure: same frame, out_ready toggling 1,0,0,1 pattern. Outputs hold stable during stalls; 32 handshakes total, order unchanged.
- Ping-pong full: three frames back-to-back with out_ready=0.
  - in_ready=0 after frame 2; frame 3 pairs drop and overflow=1.
  - Then out_ready=1 drains frame 1 (values intact), then frame 2.
- Overlap: frame 2 written while frame 1 drains with out_ready=1. Continuous output of 64 samples with no gap beyond the first frame's latency.
- Reset mid-drain: assert nrst=0 at bin 10.
  - Immediately out_valid=0, in_ready=1, overflow=0.
  - A new frame afterwards outputs correctly from bin 0.
- flush after 5 pairs accepted: wr_cnt cleared; next 16 pairs form a clean frame; out_index restarts at 0.

Source files
------------

// File: rtl/fft_out_reorder.sv
// Output reorder stage for the radix-2 FFT core: captures dual-lane pairs into a
// ping-pong frame buffer and replays each frame as a natural-order valid/ready stream.
module fft_out_reorder #(
   parameter int BW    = 16,
   parameter int LOG2N = 5
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [BW-1:0]    in_re0,
   input  logic [BW-1:0]    in_im0,
   input  logic [BW-1:0]    in_re1,
   input  logic [BW-1:0]    in_im1,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BW-1:0]    out_re,
   output logic [BW-1:0]    out_im,
   output logic [LOG2N-1:0] out_index,
   output logic             out_last,
   output logic             overflow
);

   localparam int N    = 1 << LOG2N;
   localparam int HALF = N / 2;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_t;

   bank_state_t      r_bankState     [2];
   bank_state_t      w_bankStateNext [2];

   logic [2*BW-1:0]  r_mem [2][N];
   logic             r_wb;
   logic             r_rb;
   logic [LOG2N-2:0] r_wrCnt;
   logic [LOG2N-1:0] r_rdCnt;
   logic             r_overflow;

   logic [1:0]       w_full;
   logic             w_accept;
   logic             w_drop;
   logic             w_wrLast;
   logic             w_handshake;
   logic             w_rdLast;
   logic [2*BW-1:0]  w_rdWord;

   // A bank counts as full from its last write until its last sample is taken.
   assign w_full[0]   = (r_bankState[0] == BANK_FULL) || (r_bankState[0] == BANK_DRAINING);
   assign w_full[1]   = (r_bankState[1] == BANK_FULL) || (r_bankState[1] == BANK_DRAINING);

   assign in_ready    = ~w_full[r_wb];
   assign w_accept    = in_valid & in_ready & ~flush;
   assign w_drop      = in_valid & ~in_ready & ~flush;
   assign w_wrLast    = w_accept & (r_wrCnt == (LOG2N-1)'(HALF-1));

   assign out_valid   = w_full[r_rb];
   assign w_handshake = out_valid & out_ready & ~flush;
   assign w_rdLast    = w_handshake & (r_rdCnt == LOG2N'(N-1));

   assign w_rdWord    = r_mem[r_rb][r_rdCnt];
   assign out_re      = out_valid ? w_rdWord[2*BW-1:BW] : '0;
   assign out_im      = out_valid ? w_rdWord[BW-1:0]    : '0;
   assign out_index   = out_valid ? r_rdCnt : '0;
   assign out_last    = out_valid & (r_rdCnt == LOG2N'(N-1));
   assign overflow    = r_overflow;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         w_bankStateNext[b] = r_bankState[b];
         unique case (r_bankState[b])
            BANK_EMPTY: begin
               if (w_accept && (r_wb == 1'(b)))
                  w_bankStateNext[b] = w_wrLast ? BANK_FULL : BANK_FILLING;
            end
            BANK_FILLING: begin
               if (w_wrLast && (r_wb == 1'(b)))
                  w_bankStateNext[b] = BANK_FULL;
            end
            BANK_FULL: begin
               if (w_handshake && (r_rb == 1'(b)))
                  w_bankStateNext[b] = w_rdLast ? BANK_EMPTY : BANK_DRAINING;
            end
            BANK_DRAINING: begin
               if (w_rdLast && (r_rb == 1'(b)))
                  w_bankStateNext[b] = BANK_EMPTY;
            end
            default: w_bankStateNext[b] = BANK_EMPTY;
         endcase
         if (flush)
            w_bankStateNext[b] = BANK_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_bankState[0] <= BANK_EMPTY;
         r_bankState[1] <= BANK_EMPTY;
      end else begin
         r_bankState[0] <= w_bankStateNext[0];
         r_bankState[1] <= w_bankStateNext[1];
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wb       <= 1'b0;
         r_rb       <= 1'b0;
         r_wrCnt    <= '0;
         r_rdCnt    <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_wb       <= 1'b0;
         r_rb       <= 1'b0;
         r_wrCnt    <= '0;
         r_rdCnt    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wrCnt <= w_wrLast ? '0 : r_wrCnt + 1'b1;
            if (w_wrLast)
               r_wb <= ~r_wb;
         end
         if (w_handshake) begin
            r_rdCnt <= w_rdLast ? '0 : r_rdCnt + 1'b1;
            if (w_rdLast)
               r_rb <= ~r_rb;
         end
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

   // Lane 0 carries bin k, lane 1 carries bin k+N/2, so the pair lands in both halves.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wb][{1'b0, r_wrCnt}] <= {in_re0, in_im0};
         r_mem[r_wb][{1'b1, r_wrCnt}] <= {in_re1, in_im1};
      end
   end

endmodule
